reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
Producer-side companion to the operand-forwarding select logic. Issue records which destination registers have writes in flight; writeback clears them. The block raises a load-use stall when an issuing instruction reads a register whose pending writer is a load, because forwarding cannot cover that case. It sits between decode/issue and the writeback stage of the pipelined RISC-V core.

Parameters:
ADDR_WIDTH, 5, register address width; register count NUM_REGS = 2**ADDR_WIDTH.
CNT_WIDTH, 8, width of the saturating stall-cycle counter.

Ports:
clk  input  1  core clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
issue_valid  input  1  instruction presented for issue this cycle.
issue_we  input  1  issuing instruction writes a destination register.
issue_is_load  input  1  issuing instruction is a load.
issue_rd  input  ADDR_WIDTH  destination register of the issuing instruction.
issue_rs1  input  ADDR_WIDTH  source register 1.
issue_rs2  input  ADDR_WIDTH  source register 2.
issue_use_rs1  input  1  rs1 is actually read.
issue_use_rs2  input  1  rs2 is actually read.
wb_valid  input  1  writeback retiring a register write this cycle.
wb_rd  input  ADDR_WIDTH  writeback destination.
flush  input  1  pipeline flush (branch/jump redirect).
stall  output  1  hold issue; combinational.
issue_fire  output  1  issue_valid && !stall && !flush; combinational.
pending  output  NUM_REGS  per-register in-flight write bits; registered.
stall_count  output  CNT_WIDTH  saturating count of stalled issue cycles; registered.

Behaviour:
- Reset (rst_n low, asynchronous): pending=0, load_pend=0 (internal, NUM_REGS bits), stall_count=0. With all bits clear, stall=0.
- Register x0: never set pending. Issue or writeback to x0 is ignored. Reading x0 never stalls.
- Hazard on rs1: issue_use_rs1 && rs1!=0 && load_pend[rs1] && !(wb_valid && wb_rd==rs1).
- Hazard on rs2: same rule with rs2.
- stall = issue_valid && !flush && (hazard on rs1 || hazard on rs2).
- A same-cycle writeback to the source clears the hazard, because WB-stage data is forwarded.
- Non-load pending writers never stall; they are covered by forwarding.
- Clock edge, no flush, in this order (later step wins for the same register):
  1. If wb_valid && wb_rd!=0: clear pending[wb_rd] and load_pend[wb_rd].
  2. If issue_fire && issue_we && issue_rd!=0: set pending[issue_rd]=1 and load_pend[issue_rd]=issue_is_load.
- Consequence: a simultaneous issue and writeback to the same rd leaves the bits set, reflecting the new writer.
- Re-issue to an already-pending rd overwrites load_pend with the newest writer's type.
- Flush: on the clock edge, clear all pending and load_pend bits. Issue and writeback are ignored that cycle. stall_count is not changed by flush.
- stall_count: increments by 1 on each edge where stall=1 and saturates at all-ones. It has no wrap-around.
- Latency: stall is same-cycle combinational. pending updates are visible the cycle after the edge.
- issue_* inputs hold stable while stall=1; this is the upstream contract. The block has no internal queue.
- Reset asserted mid-operation: all state clears immediately and stall drops in the same cycle.

Test Plan:
- Reset → pending=0, stall=0, stall_count=0. Issue of x0 writers (issue_rd=0) → pending stays 0.
- Load-use: cycle 0 issue load rd=5. Cycle 1 issue rs1=5, use_rs1=1 → stall=1, stall_count=1 next edge. Cycle 2 wb_rd=5 → stall=0 that cycle, issue fires, pending[5]=0.
- ALU producer: issue add rd=7, then rs2=7 next cycle → stall=0, pending[7]=1 until wb_rd=7.
- Same-cycle clash: pending[9] set by load. Issue load rd=9 and wb_rd=9 on the same edge → pending[9]=1, load_pend[9]=1 afterwards.
- Flush: loads pending on x3 and x4, flush=1 with issue_valid=1 rd=6 → next cycle pending=0, x6 not set, stall=0.
- Saturation: with CNT_WIDTH=8, hold a stall for 300 cycles → stall_count=255. Assert rst_n low mid-stall → stall=0 and stall_count=0 immediately.

Source files
------------

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register write-in-flight scoreboard with load-use stall detection.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   issue_valid/we      : instruction presented for issue / it writes issue_rd
//   issue_is_load       : issuing instruction is a load
//   issue_rd/rs1/rs2    : destination and source register addresses
//   issue_use_rs1/rs2   : source operand is actually read
//   wb_valid, wb_rd     : writeback retiring a register write
//   flush               : pipeline redirect, clears all in-flight state
//   stall               : combinational hold-issue request
//   issue_fire          : combinational, instruction accepted this cycle
//   pending             : registered per-register in-flight write bits
//   stall_count         : registered saturating count of stalled cycles
module reg_scoreboard #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH = 8,
    localparam int NUM_REGS = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic                  issue_is_load,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue_fire,
    output logic [NUM_REGS-1:0]   pending,
    output logic [CNT_WIDTH-1:0]  stall_count
);
    logic [NUM_REGS-1:0] load_pend;
    logic [NUM_REGS-1:0] wb_clr;
    logic [NUM_REGS-1:0] iss_set;
    logic                haz_rs1;
    logic                haz_rs2;

    // A same-cycle writeback to the source is forwarded from WB, so it hides the hazard.
    assign haz_rs1 = issue_use_rs1 && issue_rs1 != '0 && load_pend[issue_rs1] &&
                     !(wb_valid && wb_rd == issue_rs1);
    assign haz_rs2 = issue_use_rs2 && issue_rs2 != '0 && load_pend[issue_rs2] &&
                     !(wb_valid && wb_rd == issue_rs2);
    assign stall = issue_valid && !flush && (haz_rs1 || haz_rs2);
    assign issue_fire = issue_valid && !stall && !flush;

    // Set mask is applied after the clear mask so a new writer wins over a retiring one.
    assign wb_clr = (wb_valid && wb_rd != '0) ? (NUM_REGS'(1) << wb_rd) : '0;
    assign iss_set = (issue_fire && issue_we && issue_rd != '0) ? (NUM_REGS'(1) << issue_rd) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            load_pend <= '0;
            stall_count <= '0;
        end else begin
            pending <= flush ? '0 : (pending & ~wb_clr) | iss_set;
            load_pend <= flush ? '0 : (load_pend & ~wb_clr & ~iss_set) | (issue_is_load ? iss_set : '0);
            if (stall && stall_count != '1)
                stall_count <= stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard.
module tb_reg_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_we, issue_is_load;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        issue_use_rs1, issue_use_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic        stall, issue_fire;
    logic [31:0] pending;
    logic [7:0]  stall_count;
    int          n_cmp = 0;
    int          n_err = 0;

    reg_scoreboard #(.ADDR_WIDTH(5), .CNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_is_load(issue_is_load),
        .issue_rd(issue_rd), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
        .stall(stall), .issue_fire(issue_fire),
        .pending(pending), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_we = 0; issue_is_load = 0;
        issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
        issue_use_rs1 = 0; issue_use_rs2 = 0;
        wb_valid = 0; wb_rd = 0; flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic ld, input logic [4:0] rd);
        idle();
        issue_valid = 1; issue_we = 1; issue_is_load = ld; issue_rd = rd;
    endtask

    initial begin
        idle();
        #12;
        chk("reset_pending", pending, 32'h0);
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_count", {24'b0, stall_count}, 32'h0);
        rst_n = 1;
        tick();

        // x0 writer is ignored
        issue(1, 0);
        #1 chk("x0_fire", {31'b0, issue_fire}, 32'h1);
        tick();
        chk("x0_pending", pending, 32'h0);

        // load-use on x5
        issue(1, 5);
        tick();
        chk("ld5_pending", pending, 32'h20);
        idle();
        issue_valid = 1; issue_rs1 = 5; issue_use_rs1 = 1;
        #1 chk("lu_stall", {31'b0, stall}, 32'h1);
        chk("lu_nofire", {31'b0, issue_fire}, 32'h0);
        tick();
        chk("lu_count", {24'b0, stall_count}, 32'h1);
        chk("lu_still_stall", {31'b0, stall}, 32'h1);
        wb_valid = 1; wb_rd = 5;
        #1 chk("lu_wb_stall", {31'b0, stall}, 32'h0);
        chk("lu_wb_fire", {31'b0, issue_fire}, 32'h1);
        tick();
        chk("lu_wb_pending", pending, 32'h0);
        chk("lu_wb_count", {24'b0, stall_count}, 32'h1);

        // ALU producer on x7 is forwarded, never stalls
        issue(0, 7);
        tick();
        chk("alu_pending", pending, 32'h80);
        idle();
        issue_valid = 1; issue_rs2 = 7; issue_use_rs2 = 1;
        #1 chk("alu_stall", {31'b0, stall}, 32'h0);
        tick();
        chk("alu_pending_hold", pending, 32'h80);
        idle();
        wb_valid = 1; wb_rd = 7;
        tick();
        chk("alu_wb_pending", pending, 32'h0);

        // reading x0 never stalls
        idle();
        issue_valid = 1; issue_use_rs1 = 1; issue_use_rs2 = 1;
        #1 chk("x0_read_stall", {31'b0, stall}, 32'h0);

        // same-cycle issue and writeback on x9
        issue(1, 9);
        tick();
        issue(1, 9);
        wb_valid = 1; wb_rd = 9;
        #1 chk("clash_fire", {31'b0, issue_fire}, 32'h1);
        tick();
        chk("clash_pending", pending, 32'h200);
        idle();
        issue_valid = 1; issue_rs1 = 9; issue_use_rs1 = 1;
        #1 chk("clash_loadpend", {31'b0, stall}, 32'h1);
        // re-issue x9 as ALU writer overwrites the load type
        issue(0, 9);
        tick();
        idle();
        issue_valid = 1; issue_rs2 = 9; issue_use_rs2 = 1;
        #1 chk("reissue_alu_stall", {31'b0, stall}, 32'h0);
        idle();
        wb_valid = 1; wb_rd = 9;
        tick();
        chk("x9_cleared", pending, 32'h0);

        // flush clears everything and blocks the concurrent issue
        issue(1, 3);
        tick();
        issue(1, 4);
        tick();
        chk("flush_pre", pending, 32'h18);
        issue(1, 6);
        issue_rs1 = 3; issue_use_rs1 = 1; flush = 1;
        #1 chk("flush_stall", {31'b0, stall}, 32'h0);
        chk("flush_nofire", {31'b0, issue_fire}, 32'h0);
        tick();
        chk("flush_pending", pending, 32'h0);
        chk("flush_count", {24'b0, stall_count}, 32'h1);
        idle();
        issue_valid = 1; issue_rs1 = 3; issue_use_rs1 = 1;
        #1 chk("flush_post_stall", {31'b0, stall}, 32'h0);

        // saturation of the stall counter
        issue(1, 10);
        tick();
        idle();
        issue_valid = 1; issue_rs1 = 10; issue_use_rs1 = 1;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_count", {24'b0, stall_count}, 32'hff);
        chk("sat_stall", {31'b0, stall}, 32'h1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_stall", {31'b0, stall}, 32'h0);
        chk("rst_mid_count", {24'b0, stall_count}, 32'h0);
        chk("rst_mid_pending", pending, 32'h0);
        idle();
        tick();
        rst_n = 1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
